// File: rtl/mio_pkg.sv
// Shared definitions for the CPU memory-bus responder: address map,
// FSM state encoding and decoded target selection.
package mio_pkg;

  localparam logic [31:0] RAM_BASE  = 32'h0000_0000;
  localparam logic [31:0] LED_ADDR  = 32'hF000_0000;
  localparam logic [31:0] SW_ADDR   = 32'hF000_0004;
  localparam logic [31:0] TICK_ADDR = 32'hF000_0008;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    T_RAM,
    T_LED,
    T_SW,
    T_TICK,
    T_NONE
  } target_t;

endpackage

// File: rtl/mio_bus_responder_if.sv
// CPU-side memory bus: request/address/data from the CPU, data/ready back.
interface mio_bus_responder_if;
  logic        mem_r;
  logic        mem_w;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  modport master (output mem_r, mem_w, addr, wdata, input rdata, ready);
  modport slave  (input mem_r, mem_w, addr, wdata, output rdata, ready);
endinterface

// File: rtl/mio_bus_responder_addr_decode.sv
// Combinational address decoder: byte address -> bus target.
module mio_addr_decode
  import mio_pkg::*;
#(
  parameter int unsigned RAM_AW = 10
) (
  input  logic [31:0] addr,
  output target_t     target
);

  logic [31:0] w_word;

  // Byte offset is ignored; RAM occupies the low 4*2^RAM_AW bytes.
  assign w_word = {addr[31:2], 2'b00};

  always_comb begin
    target = T_NONE;
    if (((addr - RAM_BASE) >> (RAM_AW + 2)) == '0) target = T_RAM;
    else if (w_word == LED_ADDR)                  target = T_LED;
    else if (w_word == SW_ADDR)                   target = T_SW;
    else if (w_word == TICK_ADDR)                 target = T_TICK;
  end

endmodule

// File: rtl/mio_bus_responder.sv
// Memory/IO responder for the multi-cycle CPU bus: RAM with wait states,
// LED/switch/tick registers, unmapped space answered with zero.
module mio_bus_responder
  import mio_pkg::*;
#(
  parameter int unsigned RAM_WAIT = 1,
  parameter int unsigned RAM_AW   = 10
) (
  input  logic               clk,
  input  logic               reset,
  mio_bus_responder_if.slave bus,
  output logic [RAM_AW-1:0]  ram_addr,
  output logic [31:0]        ram_din,
  output logic               ram_we,
  input  logic [31:0]        ram_dout,
  input  logic [15:0]        sw,
  output logic [15:0]        led,
  output logic [31:0]        tick
);

  state_t      r_state, w_next;
  target_t     w_target;
  logic        w_req, w_wr, w_accept, w_ram_last;
  logic [31:0] r_cnt, r_rdata, r_tick, w_io_rdata;
  logic [15:0] r_led;

  mio_addr_decode #(.RAM_AW(RAM_AW)) u_dec (
    .addr   (bus.addr),
    .target (w_target)
  );

  assign w_req      = bus.mem_r | bus.mem_w;
  assign w_wr       = bus.mem_w;
  assign w_accept   = (r_state == IDLE) && w_req;
  assign w_ram_last = (r_state == WAIT) && (r_cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_req) w_next = (w_target == T_RAM) ? WAIT : DONE;
      WAIT:    if (r_cnt == '0) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_io_rdata = '0;
    case (w_target)
      T_LED:   w_io_rdata = {16'h0000, r_led};
      T_SW:    w_io_rdata = {16'h0000, sw};
      T_TICK:  w_io_rdata = r_tick;
      default: w_io_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_rdata <= '0;
      r_led   <= '0;
      r_tick  <= '0;
    end else begin
      r_tick <= r_tick + 32'd1;
      if (w_accept && w_target == T_RAM)
        r_cnt <= 32'(RAM_WAIT - 1);
      else if (r_state == WAIT && r_cnt != '0)
        r_cnt <= r_cnt - 32'd1;
      // IO side completes on the accept edge; a tick write overrides the increment.
      if (w_accept && w_target != T_RAM) begin
        if (w_wr) begin
          if (w_target == T_LED)  r_led  <= bus.wdata[15:0];
          if (w_target == T_TICK) r_tick <= bus.wdata;
        end else begin
          r_rdata <= w_io_rdata;
        end
      end
      if (w_ram_last && !w_wr) r_rdata <= ram_dout;
    end
  end

  assign bus.rdata = r_rdata;
  assign bus.ready = (r_state == DONE);
  assign ram_addr  = bus.addr[RAM_AW+1:2];
  assign ram_din   = bus.wdata;
  assign ram_we    = (r_state == IDLE) && bus.mem_w && (w_target == T_RAM);
  assign led       = r_led;
  assign tick      = r_tick;

endmodule

// File: tb/tb_mio_bus_responder.sv
// Self-checking bench for mio_bus_responder: directed scenarios plus a
// randomized mix checked against an address-map level reference model.
module tb_mio_bus_responder;
  import mio_pkg::*;

  localparam int unsigned RAM_WAIT = 3;
  localparam int unsigned RAM_AW   = 10;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_din;
  logic              ram_we;
  logic [31:0]       ram_dout = '0;
  logic [15:0]       sw = '0;
  logic [15:0]       led;
  logic [31:0]       tick;

  mio_bus_responder_if bus ();

  mio_bus_responder #(.RAM_WAIT(RAM_WAIT), .RAM_AW(RAM_AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_we   (ram_we),
    .ram_dout (ram_dout),
    .sw       (sw),
    .led      (led),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  // External synchronous block RAM.
  logic [31:0] ram_mem [1 << RAM_AW];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_din;
    ram_dout <= ram_mem[ram_addr];
  end

  property p_hold;
    @(posedge clk) disable iff (reset)
      (bus.mem_r | bus.mem_w) && !bus.ready |=>
        bus.ready || $stable({bus.mem_r, bus.mem_w, bus.addr, bus.wdata});
  endproperty
  a_hold: assert property (p_hold) else $error("FAIL protocol_hold: request changed before ready");

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0]  ref_mem [int];
  int unsigned  ram_words [$];
  logic [15:0]  exp_led = '0;

  // 0 RAM, 1 LED, 2 SW, 3 TICK, 4 unmapped
  function automatic int exp_target(input logic [31:0] a);
    logic [31:0] w;
    w = a & 32'hFFFF_FFFC;
    if (a < (32'd4 << RAM_AW)) return 0;
    if (w == 32'hF000_0000)    return 1;
    if (w == 32'hF000_0004)    return 2;
    if (w == 32'hF000_0008)    return 3;
    return 4;
  endfunction

  function automatic int exp_latency(input logic [31:0] a);
    return (exp_target(a) == 0) ? int'(RAM_WAIT) + 1 : 1;
  endfunction

  task automatic run_txn(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                         output int lat, output logic [31:0] rd, output int we_n,
                         output logic [RAM_AW-1:0] acc_addr);
    @(posedge clk); #1;
    bus.mem_r = r; bus.mem_w = w; bus.addr = a; bus.wdata = d;
    #1;
    we_n = int'(ram_we);
    acc_addr = ram_addr;
    lat = -1;
    rd = '0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (ram_we) we_n++;
      if (bus.ready) begin
        lat = n;
        rd = bus.rdata;
        break;
      end
    end
    bus.mem_r = 1'b0; bus.mem_w = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", bus.ready); end
    checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", bus.rdata); end
    checks++; if (led !== 16'h0) begin errors++; $display("FAIL reset_led: got %h want 0", led); end
    checks++; if (tick !== 32'h0) begin errors++; $display("FAIL reset_tick: got %h want 0", tick); end
    reset = 1'b0;
  endtask

  task automatic test_io();
    int lat, we_n; logic [31:0] rd; logic [RAM_AW-1:0] ra;
    run_txn(1'b0, 1'b1, 32'hF000_0000, 32'h0000_ABCD, lat, rd, we_n, ra);
    exp_led = 16'hABCD;
    checks++; if (lat !== 1) begin errors++; $display("FAIL io_wr_latency: got %0d want 1", lat); end
    checks++; if (led !== exp_led) begin errors++; $display("FAIL io_wr_led: got %h want %h", led, exp_led); end
    checks++; if (we_n !== 0) begin errors++; $display("FAIL io_wr_ram_we: got %0d want 0", we_n); end
    @(posedge clk); #1;
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL ready_one_cycle: got %b want 0", bus.ready); end
    run_txn(1'b1, 1'b0, 32'hF000_0000, 32'h0, lat, rd, we_n, ra);
    checks++; if (rd !== 32'h0000_ABCD) begin errors++; $display("FAIL io_rd_data: got %h want 0000abcd", rd); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL io_rd_latency: got %0d want 1", lat); end
  endtask

  task automatic test_ram();
    int lat, we_n; logic [31:0] rd; logic [RAM_AW-1:0] ra;
    run_txn(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, lat, rd, we_n, ra);
    ref_mem[4] = 32'hDEAD_BEEF; ram_words.push_back(4);
    checks++; if (we_n !== 1) begin errors++; $display("FAIL ram_we_cycles: got %0d want 1", we_n); end
    checks++; if (ra !== 10'd4) begin errors++; $display("FAIL ram_addr: got %0d want 4", ra); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL ram_wr_latency: got %0d want 4", lat); end
    run_txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, lat, rd, we_n, ra);
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_rd_data: got %h want deadbeef", rd); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL ram_rd_latency: got %0d want 4", lat); end
    checks++; if (we_n !== 0) begin errors++; $display("FAIL ram_rd_we: got %0d want 0", we_n); end
  endtask

  task automatic test_unmapped_sw();
    int lat, we_n; logic [31:0] rd; logic [RAM_AW-1:0] ra;
    run_txn(1'b1, 1'b0, 32'h8000_0000, 32'h0, lat, rd, we_n, ra);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL unmapped_rd: got %h want 0", rd); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL unmapped_latency: got %0d want 1", lat); end
    sw = 16'h1234;
    run_txn(1'b0, 1'b1, 32'hF000_0004, 32'hFFFF_5555, lat, rd, we_n, ra);
    checks++; if (led !== exp_led) begin errors++; $display("FAIL sw_write_led: got %h want %h", led, exp_led); end
    run_txn(1'b1, 1'b0, 32'hF000_0004, 32'h0, lat, rd, we_n, ra);
    checks++; if (rd !== 32'h0000_1234) begin errors++; $display("FAIL sw_rd: got %h want 00001234", rd); end
  endtask

  task automatic test_tick();
    @(posedge clk); #1;
    bus.mem_r = 1'b0; bus.mem_w = 1'b1; bus.addr = 32'hF000_0008; bus.wdata = 32'hFFFF_FFFE;
    @(posedge clk); #1;
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL tick_wr_ready: got %b want 1", bus.ready); end
    bus.mem_w = 1'b0;
    checks++; if (tick !== 32'hFFFF_FFFE) begin errors++; $display("FAIL tick_load: got %h want fffffffe", tick); end
    @(posedge clk); #1;
    checks++; if (tick !== 32'hFFFF_FFFF) begin errors++; $display("FAIL tick_inc: got %h want ffffffff", tick); end
    @(posedge clk); #1;
    checks++; if (tick !== 32'h0) begin errors++; $display("FAIL tick_wrap: got %h want 0", tick); end
  endtask

  task automatic test_both_rw();
    int lat, we_n; logic [31:0] rd; logic [RAM_AW-1:0] ra;
    run_txn(1'b1, 1'b1, 32'hF000_0000, 32'h0000_0005, lat, rd, we_n, ra);
    exp_led = 16'h0005;
    checks++; if (led !== exp_led) begin errors++; $display("FAIL both_rw_led: got %h want %h", led, exp_led); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL both_rw_latency: got %0d want 1", lat); end
  endtask

  task automatic test_reset_mid();
    int lat, we_n, pulses; logic [31:0] rd; logic [RAM_AW-1:0] ra;
    @(posedge clk); #1;
    bus.mem_r = 1'b0; bus.mem_w = 1'b1; bus.addr = 32'h0000_0020; bus.wdata = 32'h1357_9BDF;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    bus.mem_w = 1'b0;
    #1;
    checks++; if (dut.r_state !== IDLE) begin errors++; $display("FAIL reset_mid_state: got %0d want IDLE", dut.r_state); end
    @(posedge clk); #1;
    reset = 1'b0;
    exp_led = '0;
    ref_mem[8] = 32'h1357_9BDF; ram_words.push_back(8);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.ready) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL reset_mid_ready: got %0d pulses want 0", pulses); end
    checks++; if (led !== 16'h0) begin errors++; $display("FAIL reset_mid_led: got %h want 0", led); end
    run_txn(1'b1, 1'b0, 32'h0000_0020, 32'h0, lat, rd, we_n, ra);
    checks++; if (rd !== 32'h1357_9BDF) begin errors++; $display("FAIL reset_mid_commit: got %h want 13579bdf", rd); end
  endtask

  task automatic test_back_to_back();
    int lat, we_n, pulses, first, second; logic [31:0] rd, va, vb; logic [RAM_AW-1:0] ra;
    va = $urandom(); vb = $urandom();
    run_txn(1'b0, 1'b1, 32'h0000_0040, va, lat, rd, we_n, ra);
    run_txn(1'b0, 1'b1, 32'h0000_0044, vb, lat, rd, we_n, ra);
    ref_mem[16] = va; ref_mem[17] = vb; ram_words.push_back(16); ram_words.push_back(17);
    @(posedge clk); #1;
    bus.mem_r = 1'b1; bus.mem_w = 1'b0; bus.addr = 32'h0000_0040;
    pulses = 0; first = -1; second = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (bus.ready) begin
        pulses++;
        if (pulses == 1) begin
          first = n;
          checks++; if (bus.rdata !== va) begin errors++; $display("FAIL b2b_data0: got %h want %h", bus.rdata, va); end
          bus.addr = 32'h0000_0044;
        end else if (pulses == 2) begin
          second = n;
          checks++; if (bus.rdata !== vb) begin errors++; $display("FAIL b2b_data1: got %h want %h", bus.rdata, vb); end
          bus.mem_r = 1'b0;
        end
      end
    end
    bus.mem_r = 1'b0;
    checks++; if (pulses !== 2) begin errors++; $display("FAIL b2b_pulses: got %0d want 2", pulses); end
    checks++; if (first !== 4) begin errors++; $display("FAIL b2b_first: got %0d want 4", first); end
    checks++; if (second !== 4 + 1 + int'(RAM_WAIT) + 1) begin errors++; $display("FAIL b2b_second: got %0d want %0d", second, 4 + 1 + int'(RAM_WAIT) + 1); end
  endtask

  task automatic test_random();
    int lat, we_n, kind, tgt; logic [31:0] rd, a, d, exp; logic [RAM_AW-1:0] ra;
    int unsigned idx;
    logic do_wr;
    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 5);
      d = $urandom();
      sw = 16'($urandom());
      do_wr = 1'($urandom());
      case (kind)
        0, 1: begin
          if (!do_wr && ram_words.size() > 0) idx = ram_words[$urandom_range(0, ram_words.size() - 1)];
          else begin idx = $urandom_range(0, (1 << RAM_AW) - 1); do_wr = 1'b1; end
          a = 32'(idx * 4 + $urandom_range(0, 3));
        end
        2: a = 32'hF000_0000 + 32'($urandom_range(0, 3));
        3: a = 32'hF000_0004 + 32'($urandom_range(0, 3));
        default: a = 32'h0001_0000 + 32'($urandom_range(0, 32'h0FFF_FFFF));
      endcase
      tgt = exp_target(a);
      run_txn(!do_wr, do_wr, a, d, lat, rd, we_n, ra);
      checks++; if (lat !== exp_latency(a)) begin errors++; $display("FAIL rnd_latency[%0d] addr=%h: got %0d want %0d", t, a, lat, exp_latency(a)); end
      if (do_wr) begin
        if (tgt == 0) begin
          if (!ref_mem.exists(int'(a >> 2))) ram_words.push_back(a >> 2);
          ref_mem[int'(a >> 2)] = d;
        end
        if (tgt == 1) exp_led = d[15:0];
        checks++; if (led !== exp_led) begin errors++; $display("FAIL rnd_led[%0d] addr=%h: got %h want %h", t, a, led, exp_led); end
      end else if (tgt != 3) begin
        case (tgt)
          0:       exp = ref_mem[int'(a >> 2)];
          1:       exp = {16'h0, exp_led};
          2:       exp = {16'h0, sw};
          default: exp = 32'h0;
        endcase
        checks++; if (rd !== exp) begin errors++; $display("FAIL rnd_rdata[%0d] addr=%h: got %h want %h", t, a, rd, exp); end
      end
    end
  endtask

  initial begin
    bus.mem_r = 1'b0; bus.mem_w = 1'b0; bus.addr = '0; bus.wdata = '0;
    test_reset();
    test_io();
    test_ram();
    test_unmapped_sw();
    test_tick();
    test_both_rw();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mio_bus_responder.md
Name: mio_bus_responder

Overview:
- Memory/IO-side responder for the multi-cycle CPU's memory bus; it is the far end of the CPU's address, write-data, read-data and ready interface.
- Decodes each CPU request to one of three targets: an external synchronous block RAM, a small peripheral register set, or unmapped space.
- Inserts the configured wait states, returns read data, and pulses ready for exactly one cycle per completed transaction.

Parameters:
- RAM_WAIT, 1: cycles spent in WAIT for a RAM access; legal range ≥1.
- RAM_AW, 10: RAM word-address width. RAM size is 2^RAM_AW words.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- mem_r  in  1  CPU read request; held stable until ready.
- mem_w  in  1  CPU write request; held stable until ready.
- addr  in  32  CPU byte address; held stable until ready.
- wdata  in  32  CPU write data; held stable until ready.
- rdata  out  32  read data to CPU; valid while ready=1.
- ready  out  1  transaction-complete pulse.
- ram_addr  out  RAM_AW  RAM word address, equal to addr[RAM_AW+1:2] (combinational).
- ram_din  out  32  RAM write data, equal to wdata (combinational).
- ram_we  out  1  RAM write enable.
- ram_dout  in  32  RAM read data, valid one cycle after the address is sampled.
- sw  in  16  switch inputs.
- led  out  16  LED register.
- tick  out  32  free-running counter value.

Behaviour:
- Reset is asynchronous, active-high, on clk. Reset values: state=IDLE, ready=0, rdata=0, led=0, tick=0, wait counter=0.
- Memory map (addr[1:0] ignored, no alignment fault):
  - 0x0000_0000 to 0x0000_0000+4·2^RAM_AW−1: RAM.
  - 0xF000_0000: LED, read/write, low 16 bits used; reads zero-extend.
  - 0xF000_0004: switches, read-only; reads zero-extend sw; writes ignored.
  - 0xF000_0008: tick, read/write.
  - Anything else: unmapped; read returns 0, write ignored, ready still issued.
- Request: req = mem_r | mem_w. If both are high, the access is a write.
- FSM states: IDLE, WAIT, DONE.
  - IDLE & req & RAM hit → WAIT; counter loaded with RAM_WAIT−1.
  - IDLE & req & non-RAM → DONE.
  - IDLE & !req → IDLE.
  - WAIT & counter==0 → DONE; otherwise the counter decrements.
  - DONE → IDLE unconditionally.
- ram_we = (state==IDLE) & mem_w & RAM hit. This gives exactly one write-enable cycle per write transaction.
- RAM read: rdata is captured from ram_dout on the WAIT cycle where counter==0.
- IO read: rdata is captured on the IDLE accept cycle. IO write updates its register on the accept-cycle edge.
- In DONE: ready=1 and rdata is held. In all other states ready=0. rdata keeps its last value between transactions.
- Latency from the accept cycle (cycle 0) to ready:
  - IO/unmapped: ready in cycle 1.
  - RAM: ready in cycle RAM_WAIT+1.
- Back-to-back: a request still asserted in the IDLE cycle after DONE is accepted as a new transaction. The minimum gap between ready pulses is one cycle.
- tick increments by 1 every cycle, wrapping 0xFFFF_FFFF → 0. A CPU write to tick loads wdata and suppresses that cycle's increment (write wins).
- Reset mid-transaction aborts it: no ready is issued. A RAM write whose ram_we cycle already occurred stays committed.
- Request inputs changing before ready is a protocol violation; behaviour is undefined and the bench checks it with an assertion.

Decomposition:
- Shared package mio_pkg holds:
  - address constants: RAM_BASE, LED_ADDR, SW_ADDR, TICK_ADDR;
  - the state encoding for IDLE, WAIT, DONE;
  - the target-select enum: T_RAM, T_LED, T_SW, T_TICK, T_NONE.
- One sub-module, mio_addr_decode: combinational, maps addr and RAM_AW to the target enum. Used by this block and reusable by the bench.

Test Plan:
- IO write then read (RAM_WAIT=1):
  - write 0x0000_ABCD to 0xF000_0000 → ready in cycle 1 and led=0xABCD;
  - then read the same address → rdata=0x0000_ABCD.
- RAM write then read (RAM_WAIT=3):
  - write 0xDEAD_BEEF to 0x0000_0010 → ram_we is high for the accept cycle only, ram_addr=4, ready in cycle 4;
  - then read the same address → rdata=0xDEAD_BEEF with ready in cycle 4.
- Unmapped and switches:
  - read 0x8000_0000 → rdata=0, ready in cycle 1;
  - write 0xF000_0004 with sw=0x1234, then read it → rdata=0x0000_1234, led unchanged.
- Tick:
  - write 0xFFFF_FFFE to 0xF000_0008 → tick=0xFFFF_FFFE, then 0xFFFF_FFFF, then 0x0000_0000 on consecutive cycles.
- Edge cases:
  - mem_r and mem_w both high to the LED address with wdata=5 → treated as a write, led=5;
  - reset asserted during RAM WAIT (RAM_WAIT=3) → ready never pulses and state is IDLE;
  - back-to-back reads of different RAM words → exactly one ready pulse each, separated by ≥1 idle cycle.
